// File: rtl/rv32i_branch_pkg.sv
// rv32i_branch_pkg: shared branch-type, BHT counter and control-state encodings
package rv32i_branch_pkg;
    localparam logic [1:0] BR_BEQ = 2'b00;
    localparam logic [1:0] BR_BNE = 2'b01;
    localparam logic [1:0] BR_BLT = 2'b10;
    localparam logic [1:0] BR_BGE = 2'b11;
    localparam logic [1:0] BHT_SNT = 2'b00;
    localparam logic [1:0] BHT_WNT = 2'b01;
    localparam logic [1:0] BHT_WT  = 2'b10;
    localparam logic [1:0] BHT_ST  = 2'b11;
    typedef enum logic {IDLE, FLUSH} ctrl_state_t;
endpackage

// File: rtl/branch_bht.sv
// branch_bht: table of 2-bit saturating counters with a combinational read port and one update port
module branch_bht
    import rv32i_branch_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(ENTRIES)-1:0] rd_idx_i,
    output logic [1:0]                 rd_ctr_o,
    input  logic                       wr_en_i,
    input  logic [$clog2(ENTRIES)-1:0] wr_idx_i,
    input  logic                       wr_taken_i
);
    logic [1:0] ctr_q [ENTRIES];
    logic [1:0] wr_old;
    logic [1:0] wr_d;
    // Read sees the stored value, so a same-cycle update to that index is not visible yet
    assign rd_ctr_o = ctr_q[rd_idx_i];
    always_comb begin
        wr_old = ctr_q[wr_idx_i];
        wr_d   = wr_taken_i ? ((wr_old == BHT_ST) ? BHT_ST : wr_old + 2'd1)
                            : ((wr_old == BHT_SNT) ? BHT_SNT : wr_old - 2'd1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= BHT_WNT;
        end else if (wr_en_i) begin
            ctr_q[wr_idx_i] <= wr_d;
        end
    end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: BHT prediction, EX-stage branch resolution, redirect/flush sequencing and mispredict count
module branch_resolve_ctrl
    import rv32i_branch_pkg::*;
#(
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    input  logic        stall_in,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [1:0]  ex_branch_type,
    input  logic        ex_is_eq,
    input  logic        ex_is_lt,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    output logic        pc_redirect_valid,
    output logic [31:0] pc_redirect_addr,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic [31:0] mispredict_cnt
);
    localparam int IW = $clog2(BHT_ENTRIES);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    ctrl_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          redir_v_q, redir_v_d;
    logic [31:0]   redir_addr_q, redir_addr_d;
    logic [31:0]   mcnt_q, mcnt_d;
    logic [1:0]    bht_ctr;
    logic          taken;
    logic          res;
    logic          mispredict;
    logic          unused_bits;

    branch_bht #(.ENTRIES(BHT_ENTRIES)) u_bht (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (if_pc[IW+1:2]),
        .rd_ctr_o   (bht_ctr),
        .wr_en_i    (res),
        .wr_idx_i   (ex_pc[IW+1:2]),
        .wr_taken_i (taken)
    );

    assign unused_bits = ^{if_pc[31:IW+2], if_pc[1:0], bht_ctr[0]};
    assign pred_taken  = bht_ctr[1];

    always_comb begin
        taken      = (ex_branch_type == BR_BEQ) ? ex_is_eq  :
                     (ex_branch_type == BR_BNE) ? ~ex_is_eq :
                     (ex_branch_type == BR_BLT) ? ex_is_lt  : ~ex_is_lt;
        // Anything reaching EX while flushing is wrong-path and must not train or count
        res        = ex_valid & ex_is_branch & ~stall_in & (state_q == IDLE);
        mispredict = res & (taken != ex_pred_taken);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        redir_v_d    = 1'b0;
        redir_addr_d = redir_addr_q;
        mcnt_d       = mcnt_q;
        if (mispredict) begin
            state_d      = FLUSH;
            cnt_d        = CW'(FLUSH_CYCLES);
            redir_v_d    = 1'b1;
            redir_addr_d = taken ? ex_target : ex_pc + 32'd4;
            mcnt_d       = (&mcnt_q) ? mcnt_q : mcnt_q + 32'd1;
        end else if (state_q == FLUSH && !stall_in) begin
            cnt_d   = cnt_q - 1'b1;
            state_d = (cnt_q == CW'(1)) ? IDLE : FLUSH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            redir_v_q    <= 1'b0;
            redir_addr_q <= '0;
            mcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            redir_v_q    <= redir_v_d;
            redir_addr_q <= redir_addr_d;
            mcnt_q       <= mcnt_d;
        end
    end

    assign pc_redirect_valid = redir_v_q;
    assign pc_redirect_addr  = redir_addr_q;
    assign flush_if_id       = (state_q == FLUSH);
    assign flush_id_ex       = (state_q == FLUSH);
    assign mispredict_cnt    = mcnt_q;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed + random stimulus against a behavioural model, checked through a scoreboard queue
module tb_branch_resolve_ctrl;
    localparam int N  = 16;
    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        stall_in;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [1:0]  ex_branch_type;
    logic        ex_is_eq;
    logic        ex_is_lt;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic        pc_redirect_valid;
    logic [31:0] pc_redirect_addr;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic [31:0] mispredict_cnt;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.BHT_ENTRIES(N), .FLUSH_CYCLES(FC)) dut (
        .clk               (clk),
        .rst               (rst),
        .if_pc             (if_pc),
        .pred_taken        (pred_taken),
        .stall_in          (stall_in),
        .ex_valid          (ex_valid),
        .ex_is_branch      (ex_is_branch),
        .ex_branch_type    (ex_branch_type),
        .ex_is_eq          (ex_is_eq),
        .ex_is_lt          (ex_is_lt),
        .ex_pc             (ex_pc),
        .ex_target         (ex_target),
        .ex_pred_taken     (ex_pred_taken),
        .pc_redirect_valid (pc_redirect_valid),
        .pc_redirect_addr  (pc_redirect_addr),
        .flush_if_id       (flush_if_id),
        .flush_id_ex       (flush_id_ex),
        .mispredict_cnt    (mispredict_cnt)
    );

    typedef struct {
        bit          chk;
        bit          pred;
        bit          rv;
        logic [31:0] addr;
        bit          fl;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    int          m_bht [N];
    bit          m_known = 0;
    bit          m_rv = 0;
    bit          m_inf = 0;
    int          m_left = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_cnt = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit br_taken(input logic [1:0] ty, input bit eq, input bit lt);
        case (ty)
            2'b00:   return eq;
            2'b01:   return !eq;
            2'b10:   return lt;
            default: return !lt;
        endcase
    endfunction

    // Push what the DUT should show during this cycle, then advance the model across the edge
    task automatic cycle();
        exp_t e;
        bit   t;
        bit   r;
        int   ix;
        e.chk  = m_known;
        e.pred = m_bht[if_pc[5:2]] >= 2;
        e.rv   = m_rv;
        e.addr = m_addr;
        e.fl   = m_inf;
        e.cnt  = m_cnt;
        sb.push_back(e);
        if (rst) begin
            m_known = 1; m_rv = 0; m_inf = 0; m_left = 0; m_addr = '0; m_cnt = '0;
            foreach (m_bht[i]) m_bht[i] = 1;
        end else begin
            t  = br_taken(ex_branch_type, ex_is_eq, ex_is_lt);
            r  = ex_valid && ex_is_branch && !stall_in && !m_inf;
            ix = int'(ex_pc[5:2]);
            m_rv = 0;
            if (m_inf && !stall_in) begin
                m_left--;
                if (m_left == 0) m_inf = 0;
            end
            if (r) begin
                m_bht[ix] = t ? ((m_bht[ix] < 3) ? m_bht[ix] + 1 : 3) : ((m_bht[ix] > 0) ? m_bht[ix] - 1 : 0);
                if (t != ex_pred_taken) begin
                    m_inf = 1; m_left = FC; m_rv = 1;
                    m_addr = t ? ex_target : ex_pc + 32'd4;
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic br(input logic [1:0] ty, input bit eq, input bit lt, input bit pp,
                      input logic [31:0] pc, input logic [31:0] tgt);
        ex_valid = 1; ex_is_branch = 1; ex_branch_type = ty; ex_is_eq = eq; ex_is_lt = lt;
        ex_pred_taken = pp; ex_pc = pc; ex_target = tgt;
        cycle();
        ex_valid = 0;
    endtask

    task automatic idle(input int n);
        ex_valid = 0;
        stall_in = 0;
        repeat (n) cycle();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.chk) begin
                    chk("pred_taken", 32'(pred_taken), 32'(e.pred));
                    chk("pc_redirect_valid", 32'(pc_redirect_valid), 32'(e.rv));
                    chk("pc_redirect_addr", pc_redirect_addr, e.addr);
                    chk("flush_if_id", 32'(flush_if_id), 32'(e.fl));
                    chk("flush_id_ex", 32'(flush_id_ex), 32'(e.fl));
                    chk("mispredict_cnt", mispredict_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        rst = 1; if_pc = '0; stall_in = 0; ex_valid = 0; ex_is_branch = 0; ex_branch_type = '0;
        ex_is_eq = 0; ex_is_lt = 0; ex_pc = '0; ex_target = '0; ex_pred_taken = 0;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst = 0;
        idle(2);
        if_pc = 32'h100;
        br(2'b00, 1, 0, 0, 32'h100, 32'h140);
        idle(4);
        br(2'b01, 1, 0, 0, 32'h100, 32'h200);
        idle(2);
        if_pc = 32'h200;
        br(2'b10, 0, 1, 0, 32'h200, 32'h180);
        idle(4);
        br(2'b10, 0, 1, 1, 32'h200, 32'h180);
        idle(1);
        br(2'b10, 0, 1, 1, 32'h200, 32'h180);
        idle(2);
        br(2'b10, 0, 1, 1, 32'h200, 32'h180);
        idle(2);
        br(2'b11, 0, 0, 1, 32'h300, 32'h380);
        idle(1);
        br(2'b11, 0, 1, 1, 32'hFFFF_FFFC, 32'h10);
        idle(4);
        br(2'b00, 0, 0, 1, 32'h40, 32'h80);
        ex_valid = 1; ex_is_branch = 1; ex_is_eq = 1; ex_pred_taken = 0; stall_in = 1;
        repeat (3) cycle();
        stall_in = 0;
        repeat (2) cycle();
        idle(2);
        ex_valid = 1; ex_is_branch = 1; ex_branch_type = 2'b01; ex_is_eq = 0; ex_pred_taken = 0;
        ex_pc = 32'h44; ex_target = 32'h4C; stall_in = 1;
        repeat (2) cycle();
        stall_in = 0;
        cycle();
        idle(4);
        br(2'b00, 1, 0, 0, 32'h500, 32'h600);
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        for (int i = 0; i < N; i++) begin
            if_pc = 32'(i) << 2;
            cycle();
        end
        repeat (3000) begin
            rst            = ($urandom_range(0, 299) == 0);
            stall_in       = ($urandom_range(0, 3) == 0);
            ex_valid       = ($urandom_range(0, 3) != 0);
            ex_is_branch   = ($urandom_range(0, 3) != 0);
            ex_branch_type = 2'($urandom_range(0, 3));
            ex_is_eq       = 1'($urandom_range(0, 1));
            ex_is_lt       = 1'($urandom_range(0, 1));
            ex_pc          = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 63)) << 2;
            ex_target      = $urandom & 32'hFFFF_FFFC;
            ex_pred_taken  = ($urandom_range(0, 2) != 0) ? (m_bht[ex_pc[5:2]] >= 2) : 1'($urandom_range(0, 1));
            if_pc          = 32'($urandom_range(0, 63)) << 2;
            cycle();
        end
        rst = 0;
        idle(2);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
